// File: rtl/proc_pkg.sv
// Shared types for the memory stage: geometry constants, stack FSM states and
// the prioritised memory-op encoding.
package proc_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    PUSH1,
    PUSH2,
    POP1,
    POP2,
    POP3
  } mem_state_t;

  typedef enum logic [3:0] {
    OP_NONE,
    OP_INT,
    OP_CALL,
    OP_RTI,
    OP_RET,
    OP_POP,
    OP_PUSH,
    OP_LD,
    OP_ST
  } mem_op_t;

  // Resolves simultaneous flags: int > call > rti > ret > pop > push > ld > st.
  function automatic mem_op_t decode_op(input logic is_int, input logic is_call,
                                        input logic is_rti, input logic is_ret,
                                        input logic is_pop, input logic is_push,
                                        input logic is_ld, input logic is_st);
    if (is_int)       return OP_INT;
    else if (is_call) return OP_CALL;
    else if (is_rti)  return OP_RTI;
    else if (is_ret)  return OP_RET;
    else if (is_pop)  return OP_POP;
    else if (is_push) return OP_PUSH;
    else if (is_ld)   return OP_LD;
    else if (is_st)   return OP_ST;
    else              return OP_NONE;
  endfunction

endpackage

// File: rtl/sp_unit.sv
// Stack pointer: one-word push/pop steps with saturating bounds and a sticky
// error flag raised by any refused step.
module sp_unit #(
  parameter int          ADDR_W  = proc_pkg::ADDR_W,
  parameter int unsigned SP_INIT = (1 << ADDR_W) - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_req,
  input  logic              pop_req,
  output logic [ADDR_W-1:0] sp,
  output logic              push_ok,
  output logic              pop_ok,
  output logic              stack_err
);

  assign push_ok = (sp != '0);
  assign pop_ok  = (sp != ADDR_W'(SP_INIT));

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp        <= ADDR_W'(SP_INIT);
      stack_err <= 1'b0;
    end else if (push_req) begin
      if (push_ok) sp <= sp - ADDR_W'(1);
      else         stack_err <= 1'b1;
    end else if (pop_req) begin
      if (pop_ok) sp <= sp + ADDR_W'(1);
      else        stack_err <= 1'b1;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: single-word loads/stores/push/pop plus the multi-word
// CALL/INT/RET/RTI stack sequences, stall generation and MEM/WB payload.
module mem_stage #(
  parameter int          ADDR_W  = proc_pkg::ADDR_W,
  parameter int          DATA_W  = proc_pkg::DATA_W,
  parameter int unsigned SP_INIT = (1 << ADDR_W) - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              op_ld,
  input  logic              op_st,
  input  logic              op_push,
  input  logic              op_pop,
  input  logic              op_call,
  input  logic              op_ret,
  input  logic              op_rti,
  input  logic              op_int,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [31:0]       pc_in,
  input  logic [2:0]        ccr_in,
  input  logic [2:0]        rd_in,
  input  logic              reg_wr_in,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  output logic              dm_we,
  output logic              dm_re,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              stall,
  output logic              wb_valid,
  output logic              wb_reg_wr,
  output logic [2:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              pc_load,
  output logic [31:0]       pc_target,
  output logic              ccr_load,
  output logic [2:0]        ccr_val,
  output logic [ADDR_W-1:0] sp_out,
  output logic              stack_err
);
  import proc_pkg::*;

  mem_state_t        state, next_state;
  mem_op_t           op, seq_q;
  logic              ready, accept;
  logic              push_req, pop_req, push_ok, pop_ok;
  logic              mem_ld, mem_st;
  logic [DATA_W-1:0] push_data;
  logic [ADDR_W-1:0] sp;
  logic [31:0]       pc_q;
  logic [2:0]        ccr_q;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] wb_data_q;
  logic              wb_from_mem;

  // ready holds off acceptance for the first cycle after reset is released.
  assign accept = ready && in_valid && (state == IDLE);
  assign op     = accept ? decode_op(op_int, op_call, op_rti, op_ret,
                                     op_pop, op_push, op_ld, op_st) : OP_NONE;
  assign sp_out = sp;

  sp_unit #(.ADDR_W(ADDR_W), .SP_INIT(SP_INIT)) u_sp (
    .clk       (clk),
    .rst       (rst),
    .push_req  (push_req),
    .pop_req   (pop_req),
    .sp        (sp),
    .push_ok   (push_ok),
    .pop_ok    (pop_ok),
    .stack_err (stack_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      seq_q <= OP_NONE;
      ready <= 1'b0;
    end else begin
      state <= next_state;
      ready <= 1'b1;
      if (accept) seq_q <= op;
    end
  end

  // NOTE: these holding registers carry no reset; the FSM only exposes them
  // inside a sequence, which always loads them first.
  always_ff @(posedge clk) begin
    if (accept) begin
      pc_q  <= pc_in;
      ccr_q <= ccr_in;
    end else if (state == POP1) begin
      if (seq_q == OP_RET) hi_q  <= dm_rdata;
      else                 ccr_q <= dm_rdata[2:0];
    end else if (state == POP2) begin
      hi_q <= dm_rdata;
    end
  end

  // Stall covers every sequence cycle except the last, and drops on an abort
  // so the refused op leaves EX/MEM instead of being retried.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    stall      = 1'b0;
    push_req   = 1'b0;
    pop_req    = 1'b0;
    push_data  = '0;
    mem_ld     = 1'b0;
    mem_st     = 1'b0;
    pc_load    = 1'b0;
    pc_target  = '0;
    ccr_load   = 1'b0;
    ccr_val    = '0;
    case (state)
      IDLE: begin
        case (op)
          OP_INT, OP_CALL: begin
            push_req  = 1'b1;
            push_data = DATA_W'(pc_in[15:0]);
            if (push_ok) begin
              stall      = 1'b1;
              next_state = PUSH1;
            end
          end
          OP_RTI, OP_RET: begin
            pop_req = 1'b1;
            if (pop_ok) begin
              stall      = 1'b1;
              next_state = POP1;
            end
          end
          OP_PUSH: begin
            push_req  = 1'b1;
            push_data = wr_data;
          end
          OP_POP:  pop_req = 1'b1;
          OP_LD:   mem_ld  = 1'b1;
          OP_ST:   mem_st  = 1'b1;
          default: ;
        endcase
      end
      PUSH1: begin
        push_req  = 1'b1;
        push_data = DATA_W'(pc_q[31:16]);
        if (push_ok && seq_q == OP_INT) begin
          stall      = 1'b1;
          next_state = PUSH2;
        end else begin
          next_state = IDLE;
        end
      end
      PUSH2: begin
        push_req   = 1'b1;
        push_data  = DATA_W'(ccr_q);
        next_state = IDLE;
      end
      POP1: begin
        pop_req = 1'b1;
        if (pop_ok) begin
          stall      = 1'b1;
          next_state = POP2;
        end else begin
          next_state = IDLE;
        end
      end
      POP2: begin
        if (seq_q == OP_RTI) begin
          pop_req = 1'b1;
          if (pop_ok) begin
            stall      = 1'b1;
            next_state = POP3;
          end else begin
            next_state = IDLE;
          end
        end else begin
          pc_load    = 1'b1;
          pc_target  = {hi_q[15:0], dm_rdata[15:0]};
          next_state = IDLE;
        end
      end
      POP3: begin
        pc_load    = 1'b1;
        ccr_load   = 1'b1;
        pc_target  = {hi_q[15:0], dm_rdata[15:0]};
        ccr_val    = ccr_q;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Refused stack words never reach the memory port.
  always_comb begin
    dm_addr  = '0;
    dm_wdata = '0;
    dm_we    = 1'b0;
    dm_re    = 1'b0;
    if (push_req && push_ok) begin
      dm_we    = 1'b1;
      dm_addr  = sp;
      dm_wdata = push_data;
    end else if (pop_req && pop_ok) begin
      dm_re   = 1'b1;
      dm_addr = sp + ADDR_W'(1);
    end else if (mem_ld) begin
      dm_re   = 1'b1;
      dm_addr = alu_out[ADDR_W-1:0];
    end else if (mem_st) begin
      dm_we    = 1'b1;
      dm_addr  = alu_out[ADDR_W-1:0];
      dm_wdata = wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid    <= 1'b0;
      wb_reg_wr   <= 1'b0;
      wb_rd       <= '0;
      wb_data_q   <= '0;
      wb_from_mem <= 1'b0;
    end else if (accept) begin
      wb_valid    <= 1'b1;
      wb_rd       <= rd_in;
      wb_data_q   <= alu_out;
      wb_from_mem <= (op == OP_LD) || (op == OP_POP && pop_ok);
      wb_reg_wr   <= reg_wr_in && ((op == OP_NONE) || (op == OP_LD) ||
                                   (op == OP_POP && pop_ok));
    end else begin
      wb_valid    <= 1'b0;
      wb_reg_wr   <= 1'b0;
      wb_rd       <= '0;
      wb_data_q   <= '0;
      wb_from_mem <= 1'b0;
    end
  end

  // Load data arrives from memory in the write-back cycle itself.
  assign wb_data = wb_from_mem ? dm_rdata : wb_data_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a behavioural one-cycle-latency data memory.
module tb_mem_stage;

  localparam logic [7:0] F_INT  = 8'h80;
  localparam logic [7:0] F_CALL = 8'h40;
  localparam logic [7:0] F_RTI  = 8'h20;
  localparam logic [7:0] F_RET  = 8'h10;
  localparam logic [7:0] F_POP  = 8'h08;
  localparam logic [7:0] F_PUSH = 8'h04;
  localparam logic [7:0] F_LD   = 8'h02;
  localparam logic [7:0] F_ST   = 8'h01;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  ops;
  logic [15:0] alu_out, wr_data;
  logic [31:0] pc_in;
  logic [2:0]  ccr_in, rd_in;
  logic        reg_wr_in;
  logic [11:0] dm_addr;
  logic [15:0] dm_wdata, dm_rdata;
  logic        dm_we, dm_re, stall;
  logic        wb_valid, wb_reg_wr;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic        pc_load, ccr_load;
  logic [31:0] pc_target;
  logic [2:0]  ccr_val;
  logic [11:0] sp_out;
  logic        stack_err;

  logic [15:0] mem [4096];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dm_we) mem[dm_addr] <= dm_wdata;
    if (dm_re) dm_rdata <= mem[dm_addr];
  end

  mem_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .op_ld(ops[1]), .op_st(ops[0]), .op_push(ops[2]), .op_pop(ops[3]),
    .op_call(ops[6]), .op_ret(ops[4]), .op_rti(ops[5]), .op_int(ops[7]),
    .alu_out(alu_out), .wr_data(wr_data), .pc_in(pc_in), .ccr_in(ccr_in),
    .rd_in(rd_in), .reg_wr_in(reg_wr_in),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_re(dm_re),
    .dm_rdata(dm_rdata), .stall(stall),
    .wb_valid(wb_valid), .wb_reg_wr(wb_reg_wr), .wb_rd(wb_rd), .wb_data(wb_data),
    .pc_load(pc_load), .pc_target(pc_target), .ccr_load(ccr_load), .ccr_val(ccr_val),
    .sp_out(sp_out), .stack_err(stack_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic v, input logic [7:0] f, input logic [15:0] alu,
                       input logic [15:0] wd, input logic [2:0] rd, input logic rw);
    in_valid  = v;
    ops       = f;
    alu_out   = alu;
    wr_data   = wd;
    rd_in     = rd;
    reg_wr_in = rw;
  endtask

  task automatic idle();
    issue(1'b0, 8'h00, 16'h0, 16'h0, 3'd0, 1'b0);
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pc_in = '0; ccr_in = '0;
    idle();
    repeat (2) @(posedge clk);
    sample();
    check("rst_sp",       32'(sp_out),         32'hFFF);
    check("rst_stall",    32'(stall),          32'h0);
    check("rst_wb_valid", 32'(wb_valid),       32'h0);
    check("rst_err",      32'(stack_err),      32'h0);
    check("rst_dm",       32'({dm_we, dm_re}), 32'h0);
    rst = 1'b0;
    next_cycle();

    // STD then LDD round trip through address 16
    issue(1'b1, F_ST, 16'h0010, 16'hBEEF, 3'd2, 1'b1);
    sample();
    check("std_we",    32'(dm_we),    32'h1);
    check("std_addr",  32'(dm_addr),  32'h010);
    check("std_wdata", 32'(dm_wdata), 32'hBEEF);
    check("std_stall", 32'(stall),    32'h0);
    next_cycle();
    issue(1'b1, F_LD, 16'h0010, 16'h0, 3'd1, 1'b1);
    sample();
    check("ldd_re",       32'(dm_re),     32'h1);
    check("ldd_addr",     32'(dm_addr),   32'h010);
    check("ldd_stall",    32'(stall),     32'h0);
    check("std_wb_valid", 32'(wb_valid),  32'h1);
    check("std_wb_regwr", 32'(wb_reg_wr), 32'h0);
    next_cycle();
    issue(1'b1, 8'h00, 16'h5A5A, 16'h0, 3'd4, 1'b1);
    sample();
    check("ldd_wb_data",  32'(wb_data),   32'hBEEF);
    check("ldd_wb_rd",    32'(wb_rd),     32'h1);
    check("ldd_wb_regwr", 32'(wb_reg_wr), 32'h1);
    check("alu_no_mem",   32'({dm_we, dm_re}), 32'h0);
    next_cycle();

    // PUSH then POP from reset stack
    issue(1'b1, F_PUSH, 16'h0, 16'h1234, 3'd5, 1'b1);
    sample();
    check("alu_wb_data",  32'(wb_data),   32'h5A5A);
    check("alu_wb_regwr", 32'(wb_reg_wr), 32'h1);
    check("push_we",      32'(dm_we),     32'h1);
    check("push_addr",    32'(dm_addr),   32'hFFF);
    check("push_wdata",   32'(dm_wdata),  32'h1234);
    next_cycle();
    issue(1'b1, F_POP, 16'h0, 16'h0, 3'd3, 1'b1);
    sample();
    check("push_sp",       32'(sp_out),    32'hFFE);
    check("push_wb_regwr", 32'(wb_reg_wr), 32'h0);
    check("pop_re",        32'(dm_re),     32'h1);
    check("pop_addr",      32'(dm_addr),   32'hFFF);
    next_cycle();
    idle();
    sample();
    check("pop_wb_data",  32'(wb_data),   32'h1234);
    check("pop_wb_rd",    32'(wb_rd),     32'h3);
    check("pop_wb_regwr", 32'(wb_reg_wr), 32'h1);
    check("pop_sp",       32'(sp_out),    32'hFFF);
    next_cycle();

    // CALL then RET
    pc_in = 32'h0001_0020;
    issue(1'b1, F_CALL, 16'h0, 16'h0, 3'd0, 1'b1);
    sample();
    check("call0_stall", 32'(stall),    32'h1);
    check("call0_addr",  32'(dm_addr),  32'hFFF);
    check("call0_wdata", 32'(dm_wdata), 32'h0020);
    next_cycle();
    pc_in = 32'hDEAD_BEEF;
    sample();
    check("call1_stall", 32'(stall),    32'h0);
    check("call1_we",    32'(dm_we),    32'h1);
    check("call1_addr",  32'(dm_addr),  32'hFFE);
    check("call1_wdata", 32'(dm_wdata), 32'h0001);
    next_cycle();
    issue(1'b1, F_RET, 16'h0, 16'h0, 3'd0, 1'b1);
    sample();
    check("call_mem_lo",   32'(mem[4095]), 32'h0020);
    check("call_mem_hi",   32'(mem[4094]), 32'h0001);
    check("call_sp",       32'(sp_out),    32'hFFD);
    check("call_wb_regwr", 32'(wb_reg_wr), 32'h0);
    check("ret0_stall",    32'(stall),     32'h1);
    check("ret0_addr",     32'(dm_addr),   32'hFFE);
    next_cycle();
    sample();
    check("ret1_stall", 32'(stall),   32'h1);
    check("ret1_re",    32'(dm_re),   32'h1);
    check("ret1_addr",  32'(dm_addr), 32'hFFF);
    check("ret1_pcld",  32'(pc_load), 32'h0);
    next_cycle();
    sample();
    check("ret2_stall",  32'(stall),     32'h0);
    check("ret2_pcld",   32'(pc_load),   32'h1);
    check("ret2_target", pc_target,      32'h0001_0020);
    next_cycle();
    idle();
    sample();
    check("ret_pcld_end", 32'(pc_load), 32'h0);
    check("ret_sp",       32'(sp_out),  32'hFFF);
    next_cycle();

    // INT then RTI
    pc_in = 32'h0000_0100; ccr_in = 3'b101;
    issue(1'b1, F_INT, 16'h0, 16'h0, 3'd0, 1'b0);
    sample();
    check("int0_stall", 32'(stall),    32'h1);
    check("int0_wdata", 32'(dm_wdata), 32'h0100);
    next_cycle();
    ccr_in = 3'b000;
    sample();
    check("int1_stall", 32'(stall),   32'h1);
    check("int1_addr",  32'(dm_addr), 32'hFFE);
    next_cycle();
    sample();
    check("int2_stall", 32'(stall),    32'h0);
    check("int2_we",    32'(dm_we),    32'h1);
    check("int2_addr",  32'(dm_addr),  32'hFFD);
    check("int2_wdata", 32'(dm_wdata), 32'h0005);
    next_cycle();
    issue(1'b1, F_RTI, 16'h0, 16'h0, 3'd0, 1'b0);
    sample();
    check("int_sp",     32'(sp_out),  32'hFFC);
    check("rti0_stall", 32'(stall),   32'h1);
    check("rti0_addr",  32'(dm_addr), 32'hFFD);
    next_cycle();
    sample();
    check("rti1_stall", 32'(stall),   32'h1);
    check("rti1_addr",  32'(dm_addr), 32'hFFE);
    next_cycle();
    sample();
    check("rti2_stall", 32'(stall),   32'h1);
    check("rti2_addr",  32'(dm_addr), 32'hFFF);
    check("rti2_pcld",  32'(pc_load), 32'h0);
    next_cycle();
    sample();
    check("rti3_stall",  32'(stall),    32'h0);
    check("rti3_pcld",   32'(pc_load),  32'h1);
    check("rti3_ccrld",  32'(ccr_load), 32'h1);
    check("rti3_ccr",    32'(ccr_val),  32'h5);
    check("rti3_target", pc_target,     32'h0000_0100);
    next_cycle();
    idle();
    sample();
    check("rti_sp",     32'(sp_out),   32'hFFF);
    check("rti_ccr_end", 32'(ccr_load), 32'h0);
    next_cycle();

    // RET on an empty stack
    issue(1'b1, F_RET, 16'h0, 16'h0, 3'd0, 1'b0);
    sample();
    check("uf_re",    32'(dm_re),   32'h0);
    check("uf_stall", 32'(stall),   32'h0);
    check("uf_pcld",  32'(pc_load), 32'h0);
    next_cycle();
    issue(1'b1, F_LD, 16'h0010, 16'h0, 3'd1, 1'b1);
    sample();
    check("uf_err",      32'(stack_err), 32'h1);
    check("uf_pcld2",    32'(pc_load),   32'h0);
    check("uf_idle_re",  32'(dm_re),     32'h1);
    check("uf_sp",       32'(sp_out),    32'hFFF);
    next_cycle();

    // Reset in the middle of RTI
    pc_in = 32'h0000_0300; ccr_in = 3'b010;
    issue(1'b1, F_INT, 16'h0, 16'h0, 3'd0, 1'b0);
    repeat (3) next_cycle();
    issue(1'b1, F_RTI, 16'h0, 16'h0, 3'd0, 1'b0);
    next_cycle();
    #2 rst = 1'b1;
    #1;
    check("mid_rst_sp",    32'(sp_out),          32'hFFF);
    check("mid_rst_stall", 32'(stall),           32'h0);
    check("mid_rst_dm",    32'({dm_we, dm_re}),  32'h0);
    check("mid_rst_pcld",  32'({pc_load, ccr_load}), 32'h0);
    check("mid_rst_err",   32'(stack_err),       32'h0);
    issue(1'b1, F_LD, 16'h0010, 16'h0, 3'd6, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_re",    32'(dm_re),    32'h0);
    check("post_rst_valid", 32'(wb_valid), 32'h0);
    next_cycle();
    sample();
    check("post_rst_ld_re",   32'(dm_re),   32'h1);
    check("post_rst_ld_addr", 32'(dm_addr), 32'h010);
    check("post_rst_pcld",    32'(pc_load), 32'h0);
    next_cycle();
    idle();
    sample();
    check("post_rst_wb_data", 32'(wb_data), 32'hBEEF);
    check("post_rst_wb_rd",   32'(wb_rd),   32'h6);
    next_cycle();

    // Fill the stack down to SP=0, then one refused push
    for (int i = 0; i < 4095; i++) begin
      issue(1'b1, F_PUSH, 16'h0, 16'(i), 3'd0, 1'b0);
      next_cycle();
    end
    issue(1'b1, F_PUSH, 16'h0, 16'hAAAA, 3'd0, 1'b0);
    sample();
    check("full_sp",      32'(sp_out),    32'h000);
    check("full_mem1",    32'(mem[1]),    32'h0FFE);
    check("full_err_pre", 32'(stack_err), 32'h0);
    check("of_we",        32'(dm_we),     32'h0);
    next_cycle();
    idle();
    sample();
    check("of_err", 32'(stack_err), 32'h1);
    check("of_sp",  32'(sp_out),    32'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
